shift_add_mult_ctrl: RTL and testbench



---
 rtl/shift_add_mult_pkg.sv | 14 +
 rtl/ula_8_bits.sv | 67 ++++++
 rtl/shift_add_mult_ctrl.sv | 114 +++++++++++
 tb/tb_shift_add_mult_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/shift_add_mult_pkg.sv
// Shared types and constants for the shift-add multiplier controller.
package shift_add_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mult_state_t;

    localparam logic [3:0] ALU_OP_ADD    = 4'b1001;
    localparam logic [3:0] ALU_OP_PASS_A = 4'b1111;
    localparam int         MULT_STEPS    = 8;

endpackage

// File: rtl/ula_8_bits.sv
// 8-bit combinational ALU in 74181 style: m=1 selects logic, m=0 arithmetic.
// Carry-in and carry-out are active-low (c_in=1 means no carry); s=1111 in arithmetic mode passes A.
module ula_8_bits (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [3:0] s,
    input  logic       m,
    input  logic       c_in,
    output logic [7:0] f,
    output logic       c_out
);

    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] logic_f;
    logic [8:0] sum;

    always_comb begin
        x = a;
        y = 8'h00;
        case (s)
            4'b0000: begin x = a;        y = 8'h00;   end
            4'b0001: begin x = a | b;    y = 8'h00;   end
            4'b0010: begin x = a | ~b;   y = 8'h00;   end
            4'b0011: begin x = 8'h00;    y = 8'hFF;   end
            4'b0100: begin x = a;        y = a & ~b;  end
            4'b0101: begin x = a | b;    y = a & ~b;  end
            4'b0110: begin x = a;        y = ~b;      end
            4'b0111: begin x = a & ~b;   y = 8'hFF;   end
            4'b1000: begin x = a;        y = a & b;   end
            4'b1001: begin x = a;        y = b;       end
            4'b1010: begin x = a | ~b;   y = a & b;   end
            4'b1011: begin x = a & b;    y = 8'hFF;   end
            4'b1100: begin x = a;        y = a;       end
            4'b1101: begin x = a | b;    y = a;       end
            4'b1110: begin x = a | ~b;   y = a;       end
            default: begin x = a;        y = 8'h00;   end
        endcase
    end

    always_comb begin
        logic_f = 8'h00;
        case (s)
            4'b0000: logic_f = ~a;
            4'b0001: logic_f = ~(a | b);
            4'b0010: logic_f = ~a & b;
            4'b0011: logic_f = 8'h00;
            4'b0100: logic_f = ~(a & b);
            4'b0101: logic_f = ~b;
            4'b0110: logic_f = a ^ b;
            4'b0111: logic_f = a & ~b;
            4'b1000: logic_f = ~a | b;
            4'b1001: logic_f = ~(a ^ b);
            4'b1010: logic_f = b;
            4'b1011: logic_f = a & b;
            4'b1100: logic_f = 8'hFF;
            4'b1101: logic_f = a | ~b;
            4'b1110: logic_f = a | b;
            default: logic_f = a;
        endcase
    end

    assign sum   = {1'b0, x} + {1'b0, y} + {8'h00, ~c_in};
    assign f     = m ? logic_f : sum[7:0];
    assign c_out = m ? 1'b1 : ~sum[8];

endmodule

// File: rtl/shift_add_mult_ctrl.sv
// Sequential 8x8 unsigned shift-add multiplier sequencer driving ula_8_bits.
// Define SHIFT_ADD_MULT_DBG_EN to expose dbg_state/dbg_cnt.
module shift_add_mult_ctrl
    import shift_add_mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
`ifdef SHIFT_ADD_MULT_DBG_EN
    ,
    output logic [1:0]         dbg_state,
    output logic [3:0]         dbg_cnt
`endif
);

    mult_state_t      state;
    mult_state_t      state_nxt;
    logic [WIDTH-1:0] m_reg;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] q;
    logic [3:0]       cnt;

    logic             load;
    logic             step;
    logic [3:0]       alu_s;
    logic [WIDTH-1:0] alu_f;
    logic             alu_c_out;
    logic             carry;

    assign alu_s = q[0] ? ALU_OP_ADD : ALU_OP_PASS_A;

    ula_8_bits u_alu (
        .a     (acc),
        .b     (m_reg),
        .s     (alu_s),
        .m     (1'b0),
        .c_in  (1'b1),
        .f     (alu_f),
        .c_out (alu_c_out)
    );

    // The ALU flags a carry by pulling c_out low; only an add can produce one.
    assign carry = q[0] & ~alu_c_out;

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                step = 1'b1;
                if (cnt == 4'(MULT_STEPS - 1)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    load      = 1'b1;
                    state_nxt = CALC;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            m_reg <= '0;
            acc   <= '0;
            q     <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (load) begin
                m_reg <= multiplicand;
                q     <= multiplier;
                acc   <= '0;
                cnt   <= '0;
            end else if (step) begin
                acc <= {carry, alu_f[WIDTH-1:1]};
                q   <= {alu_f[0], q[WIDTH-1:1]};
                cnt <= cnt + 4'd1;
            end
        end
    end

    assign product = {acc, q};

`ifdef SHIFT_ADD_MULT_DBG_EN
    assign dbg_state = state;
    assign dbg_cnt   = cnt;
`endif

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Directed self-checking bench for shift_add_mult_ctrl (default build).
module tb_shift_add_mult_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  multiplicand;
    logic [7:0]  multiplier;
    logic        busy;
    logic        done;
    logic [15:0] product;

    int checks;
    int errors;

    shift_add_mult_ctrl #(.WIDTH(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        multiplicand = 8'h00;
        multiplier   = 8'h00;
        tick();
        tick();
        checks++;
        if (product !== 16'h0000 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: product=%h busy=%b done=%b required product=0000 busy=0 done=0",
                     product, busy, done);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (product !== 16'h0000 || busy !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL idle_no_start[%0d]: product=%h busy=%b done=%b required 0000/0/0",
                         i, product, busy, done);
            end
        end
    endtask

    task automatic test_13x11();
        multiplicand = 8'd13;
        multiplier   = 8'd11;
        start = 1'b1;
        tick();
        start = 1'b0;
        multiplicand = 8'hEE;
        multiplier   = 8'hEE;
        for (int c = 1; c <= 8; c++) begin
            checks++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL busy_13x11 cycle %0d: busy=%b done=%b required busy=1 done=0", c, busy, done);
            end
            tick();
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || product !== 16'h008F) begin
            errors++;
            $display("FAIL done_13x11: done=%b busy=%b product=%h required 1/0/008f", done, busy, product);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || product !== 16'h008F) begin
            errors++;
            $display("FAIL hold_13x11: done=%b busy=%b product=%h required 0/0/008f", done, busy, product);
        end
    endtask

    task automatic test_ff_x_ff();
        multiplicand = 8'hFF;
        multiplier   = 8'hFF;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 8; c++) tick();
        checks++;
        if (done !== 1'b1 || product !== 16'hFE01) begin
            errors++;
            $display("FAIL ff_x_ff: done=%b product=%h required 1/fe01", done, product);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        multiplicand = 8'h00;
        multiplier   = 8'h5A;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 8; c++) tick();
        checks++;
        if (done !== 1'b1 || product !== 16'h0000) begin
            errors++;
            $display("FAIL b2b_first: done=%b product=%h required 1/0000", done, product);
        end
        multiplicand = 8'h80;
        multiplier   = 8'h02;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || product !== 16'h0002) begin
            errors++;
            $display("FAIL b2b_reload: busy=%b done=%b product=%h required 1/0/0002", busy, done, product);
        end
        for (int c = 11; c <= 18; c++) tick();
        checks++;
        if (done !== 1'b1 || product !== 16'h0100) begin
            errors++;
            $display("FAIL b2b_second: done=%b product=%h required 1/0100", done, product);
        end
        tick();
    endtask

    task automatic test_start_ignored();
        multiplicand = 8'd7;
        multiplier   = 8'd9;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            if (c == 4) begin
                multiplicand = 8'd1;
                multiplier   = 8'd1;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        checks++;
        if (done !== 1'b1 || product !== 16'h003F) begin
            errors++;
            $display("FAIL start_ignored: done=%b product=%h required 1/003f", done, product);
        end
        tick();
    endtask

    task automatic test_reset_abort();
        int saw_done;
        saw_done = 0;
        multiplicand = 8'hAA;
        multiplier   = 8'h55;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 5; c++) tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== 16'h0000) begin
            errors++;
            $display("FAIL abort_async: busy=%b done=%b product=%h required 0/0/0000", busy, done, product);
        end
        tick();
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (done === 1'b1) saw_done++;
            tick();
        end
        checks++;
        if (saw_done != 0 || product !== 16'h0000) begin
            errors++;
            $display("FAIL abort_no_done: done pulses=%0d product=%h required 0/0000", saw_done, product);
        end
        multiplicand = 8'd3;
        multiplier   = 8'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 8; c++) tick();
        checks++;
        if (done !== 1'b1 || product !== 16'h0009) begin
            errors++;
            $display("FAIL after_abort_3x3: done=%b product=%h required 1/0009", done, product);
        end
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_13x11();
        test_ff_x_ff();
        test_back_to_back();
        test_start_ignored();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
